// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: power-up sequencer, pad configuration registers and input conditioning.
// Optional per-pad input debounce is compiled in with GPIO_PAD_CTRL_DEBOUNCE_EN.
//
// state   | meaning
// OFF     | waiting for start_i, pads held safe
// PWRUP   | power-up hold for PWRUP_CYCLES clocks, pads safe
// RELEASE | one clock with pwrupzhl released, pads otherwise safe
// ACTIVE  | configuration registers drive the pads, writes accepted
module gpio_pad_ctrl #(
  parameter int NUM_PADS     = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int PWRUP_CYCLES = 16,
  parameter int DEB_CYCLES   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic                active_o,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [2:0]          wr_addr_i,
  input  logic [NUM_PADS-1:0] wr_data_i,
  output logic [NUM_PADS-1:0] outi,
  output logic [NUM_PADS-1:0] enq,
  output logic [NUM_PADS-1:0] enabq,
  output logic [NUM_PADS-1:0] puq,
  output logic [NUM_PADS-1:0] pd,
  output logic [NUM_PADS-1:0] ppen,
  output logic [NUM_PADS-1:0] prg_slew,
  output logic [NUM_PADS-1:0] drv0,
  output logic [NUM_PADS-1:0] drv1,
  output logic [NUM_PADS-1:0] drv2,
  output logic [NUM_PADS-1:0] pwrup_pull_en,
  output logic [NUM_PADS-1:0] pwrupzhl,
  input  logic [NUM_PADS-1:0] dq,
  output logic [NUM_PADS-1:0] in_o
);

  localparam int PW = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam logic [NUM_PADS-1:0] ONES = {NUM_PADS{1'b1}};

  typedef enum logic [1:0] {OFF, PWRUP, RELEASE, ACTIVE} state_t;

  state_t                state;
  logic [PW-1:0]         pwr_cnt;
  logic                  active_q;
  logic                  zhl_q;
  logic [NUM_PADS-1:0]   out_r, oe_r, oe_d, ie_r, pu_r, pd_r, slew_r;
  logic [2:0]            drv_r;
  logic [2:0]            drv_wd;
  logic                  wr_en;
  logic [NUM_PADS-1:0]   oe_eff;
  logic [NUM_PADS-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_PADS-1:0]   cond_in;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= OFF;
      pwr_cnt  <= '0;
      active_q <= 1'b0;
      zhl_q    <= 1'b1;
    end else begin
      case (state)
        OFF: if (start_i) begin
          state   <= PWRUP;
          pwr_cnt <= PW'(PWRUP_CYCLES - 1);
        end
        PWRUP: begin
          if (pwr_cnt == '0) begin
            state <= RELEASE;
            zhl_q <= 1'b0;
          end else begin
            pwr_cnt <= pwr_cnt - 1'b1;
          end
        end
        RELEASE: begin
          state    <= ACTIVE;
          active_q <= 1'b1;
        end
        default: state <= ACTIVE;
      endcase
    end
  end

  assign active_o   = active_q;
  assign wr_ready_o = active_q;
  assign wr_en      = wr_valid_i & active_q;
  assign drv_wd     = 3'(wr_data_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_r  <= '0;
      oe_r   <= '0;
      oe_d   <= '0;
      ie_r   <= '0;
      pu_r   <= '0;
      pd_r   <= '0;
      slew_r <= '0;
      drv_r  <= '0;
    end else begin
      oe_d <= oe_r;
      if (wr_en) begin
        case (wr_addr_i)
          3'd0: out_r  <= wr_data_i;
          3'd1: oe_r   <= wr_data_i;
          3'd2: ie_r   <= wr_data_i;
          3'd3: pu_r   <= wr_data_i;
          3'd4: pd_r   <= wr_data_i;
          3'd5: slew_r <= wr_data_i;
          3'd6: drv_r  <= drv_wd;
          default: ;
        endcase
      end
    end
  end

  // Enabling waits an extra clock behind oe_d; disabling follows oe_r directly.
  assign oe_eff = oe_r & oe_d;

  assign outi          = active_q ? out_r : '0;
  assign enq           = active_q ? ~oe_eff : ONES;
  assign enabq         = active_q ? ~ie_r : ONES;
  assign puq           = active_q ? ~(pu_r & ~pd_r) : ONES;
  assign pd            = active_q ? pd_r : '0;
  assign ppen          = active_q ? (pu_r | pd_r) : '0;
  assign prg_slew      = active_q ? slew_r : '0;
  assign drv0          = (active_q & drv_r[0]) ? ONES : '0;
  assign drv1          = (active_q & drv_r[1]) ? ONES : '0;
  assign drv2          = (active_q & drv_r[2]) ? ONES : '0;
  assign pwrup_pull_en = active_q ? '0 : ONES;
  assign pwrupzhl      = zhl_q ? ONES : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= dq;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  logic [DW-1:0]       deb_cnt [NUM_PADS];
  logic [NUM_PADS-1:0] deb_q;

  // Counter reloads whenever the synchronised bit agrees with the held value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb_q <= '0;
      for (int p = 0; p < NUM_PADS; p++) deb_cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (sync_q[SYNC_STAGES-1][p] == deb_q[p]) begin
          deb_cnt[p] <= DW'(DEB_CYCLES - 1);
        end else if (deb_cnt[p] == '0) begin
          deb_q[p]   <= sync_q[SYNC_STAGES-1][p];
          deb_cnt[p] <= DW'(DEB_CYCLES - 1);
        end else begin
          deb_cnt[p] <= deb_cnt[p] - 1'b1;
        end
      end
    end
  end

  assign cond_in = deb_q;
`else
  assign cond_in = sync_q[SYNC_STAGES-1];
`endif

  assign in_o = cond_in & ~enabq;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed testbench for gpio_pad_ctrl: power-up sequence, register writes, OE ordering,
// pull resolution, input path latency, glitch rejection and reset behaviour.
module tb_gpio_pad_ctrl;

  localparam int NP  = 32;
  localparam int SS  = 2;
  localparam int PWC = 16;
  localparam int DC  = 4;
`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
  localparam int IN_LAT = SS + DC;
`else
  localparam int IN_LAT = SS;
`endif
  localparam logic [NP-1:0] ONES = {NP{1'b1}};

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          active_o;
  logic          wr_valid_i = 1'b0;
  logic          wr_ready_o;
  logic [2:0]    wr_addr_i = 3'd0;
  logic [NP-1:0] wr_data_i = '0;
  logic [NP-1:0] outi, enq, enabq, puq, pd, ppen, prg_slew;
  logic [NP-1:0] drv0, drv1, drv2, pwrup_pull_en, pwrupzhl;
  logic [NP-1:0] dq = '0;
  logic [NP-1:0] in_o;

  int checks = 0;
  int errors = 0;

  gpio_pad_ctrl #(.NUM_PADS(NP), .SYNC_STAGES(SS), .PWRUP_CYCLES(PWC), .DEB_CYCLES(DC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .active_o(active_o),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .outi(outi), .enq(enq), .enabq(enabq), .puq(puq),
    .pd(pd), .ppen(ppen), .prg_slew(prg_slew), .drv0(drv0), .drv1(drv1),
    .drv2(drv2), .pwrup_pull_en(pwrup_pull_en), .pwrupzhl(pwrupzhl),
    .dq(dq), .in_o(in_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [NP-1:0] d);
    wr_valid_i = 1'b1;
    wr_addr_i  = a;
    wr_data_i  = d;
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic check_safe(input string tag, input logic [NP-1:0] zhl);
    check({tag, "_active"}, NP'(active_o), '0);
    check({tag, "_ready"}, NP'(wr_ready_o), '0);
    check({tag, "_enq"}, enq, ONES);
    check({tag, "_enabq"}, enabq, ONES);
    check({tag, "_puq"}, puq, ONES);
    check({tag, "_pd"}, pd, '0);
    check({tag, "_ppen"}, ppen, '0);
    check({tag, "_outi"}, outi, '0);
    check({tag, "_drv"}, drv0 | drv1 | drv2 | prg_slew, '0);
    check({tag, "_pull_en"}, pwrup_pull_en, ONES);
    check({tag, "_zhl"}, pwrupzhl, zhl);
    check({tag, "_in"}, in_o, '0);
  endtask

  initial begin
    tick(3);
    check_safe("reset", ONES);
    rst_i = 1'b0;
    tick(5);
    check_safe("off_idle", ONES);

    // Power-up: start sampled here, re-pulse inside PWRUP must not restart the hold.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < PWC; i++) begin
      start_i = (i == 5);
      check("pwrup_zhl", pwrupzhl, ONES);
      check("pwrup_active", NP'(active_o), '0);
      wr_valid_i = 1'b1; wr_addr_i = 3'd0; wr_data_i = ONES;
      tick();
    end
    start_i = 1'b0;
    wr_valid_i = 1'b0;
    check_safe("release", '0);
    tick();
    check("act_active", NP'(active_o), NP'(1));
    check("act_ready", NP'(wr_ready_o), NP'(1));
    check("act_pull_en", pwrup_pull_en, '0);
    check("act_zhl", pwrupzhl, '0);
    check("act_outi_nowr", outi, '0);

    wr(3'd0, 32'h0000_00FF);
    check("out_ff", outi, 32'h0000_00FF);
    wr(3'd1, 32'h0000_000F);
    check("oe_on_1clk", enq, ONES);
    tick();
    check("oe_on_2clk", enq, ~32'h0000_000F);
    wr(3'd1, 32'h0);
    check("oe_off_1clk", enq, ONES);

    wr(3'd3, 32'h3);
    wr(3'd4, 32'h1);
    check("pull_puq", puq, ~32'h2);
    check("pull_pd", pd, 32'h1);
    check("pull_ppen", ppen, 32'h3);

    wr(3'd5, 32'hA5A5_0000);
    check("slew", prg_slew, 32'hA5A5_0000);
    wr(3'd6, 32'hFFFF_FFF5);
    check("drv0", drv0, ONES);
    check("drv1", drv1, '0);
    check("drv2", drv2, ONES);

    wr(3'd7, ONES);
    check("a7_outi", outi, 32'h0000_00FF);
    check("a7_enq", enq, ONES);
    check("a7_enabq", enabq, ONES);
    check("a7_puq", puq, ~32'h2);
    check("a7_pd", pd, 32'h1);
    check("a7_slew", prg_slew, 32'hA5A5_0000);
    check("a7_drv", drv0 | drv1 | drv2, ONES);
    check("a7_drv1", drv1, '0);

    dq = 32'h1;
    tick(IN_LAT + 2);
    check("in_gated", in_o, '0);
    wr(3'd2, 32'h1);
    check("ie_enabq", enabq, ~32'h1);
    check("ie_in", in_o, 32'h1);
    dq = '0;
    tick(IN_LAT + 2);
    check("in_low", in_o, '0);
    dq = 32'h1;
    tick(IN_LAT - 1);
    check("in_lat_early", in_o, '0);
    tick();
    check("in_lat", in_o, 32'h1);
`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    dq = '0;
    tick(2);
    dq = 32'h1;
    for (int i = 0; i < 10; i++) begin
      check("glitch", in_o, 32'h1);
      tick();
    end
`endif
    dq = 32'h3;
    tick(IN_LAT + 2);
    check("in_mask", in_o, 32'h1);

    // Reset mid-PWRUP: immediate safe state, no restart without a fresh start.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("active_no_restart", NP'(active_o), NP'(1));
    rst_i = 1'b1;
    #1;
    check_safe("rst_active", ONES);
    tick();
    rst_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(7);
    check("mid_zhl", pwrupzhl, ONES);
    rst_i = 1'b1;
    #1;
    check_safe("rst_mid", ONES);
    tick();
    rst_i = 1'b0;
    tick(PWC + 6);
    check_safe("no_autostart", ONES);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(PWC + 1);
    check("restart_active", NP'(active_o), NP'(1));
    check("restart_outi", outi, '0);
    check("restart_enq", enq, ONES);
    check("restart_enabq", enabq, ONES);
    check("restart_in", in_o, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
